uart_tx_fifo_ctrl: RTL and testbench
====================================

// Module: uart_tx_fifo_ctrl
// PURPOSE
//   Drain controller between the TX Fifo_buffer and the UART transmitter. Pops one word when the
//   FIFO is non-empty and transmit is enabled, launches one frame via a start pulse, waits for the
//   transmitter's done tick (with watchdog), then enforces an inter-frame gap before the next pop.
// PARAMETERS
//   W            8    data word width; matches Fifo_buffer W
//   GAP_CYC      2    idle clocks inserted after each frame (0 = none)
//   TIMEOUT_CYC  4096 max clocks in BUSY without tx_done_tick before abort (>=2)
//   CNT_W        16   width of frame_cnt
//   PARITY_ODD   0    0 = even, 1 = odd parity (used only with UART_TX_PARITY_EN)
// PORTS
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   tx_en        in   1      level; 1 = allowed to start new frames
//   fifo_empty   in   1      Fifo_buffer empty flag
//   fifo_data    in   W      Fifo_buffer data_r (head word, valid while !fifo_empty)
//   fifo_rd      out  1      one-clock pop strobe to Fifo_buffer rd
//   tx_done_tick in   1      one-clock pulse from transmitter: frame finished
//   tx_start     out  1      one-clock pulse to transmitter: send tx_data
//   tx_data      out  W      registered word for the transmitter, stable until next launch
//   tx_parity    out  1      parity bit for tx_data
//   busy         out  1      1 in any state other than IDLE
//   tx_timeout   out  1      one-clock pulse when watchdog aborts a frame
//   frame_cnt    out  CNT_W  count of completed frames, wraps modulo 2^CNT_W
// BEHAVIOUR
//   - Reset (async, any time): state=IDLE; fifo_rd, tx_start, tx_timeout, busy, tx_parity=0;
//     tx_data=0; frame_cnt=0; gap/watchdog counters=0. Mid-frame reset drops the frame; words not
//     yet popped stay in the FIFO. All outputs registered.
//   - FSM states IDLE, BUSY, GAP.
//   - IDLE: on edge with tx_en=1 & fifo_empty=0: tx_data<=fifo_data, fifo_rd<=1, tx_start<=1,
//     state<=BUSY. So fifo_rd and tx_start are high together for exactly the next cycle
//     (launch latency 1 clk). Otherwise stay; fifo_rd never asserted while fifo_empty=1.
//   - BUSY: fifo_rd/tx_start return to 0 after one cycle. tx_done_tick is ignored in the first
//     BUSY cycle (the one with tx_start=1). Later tx_done_tick: frame_cnt+=1, state<=GAP
//     (or IDLE if GAP_CYC=0). Watchdog counts from 0 on BUSY entry; on the TIMEOUT_CYC-th
//     BUSY cycle without an accepted done: tx_timeout pulses 1 clk, frame_cnt unchanged,
//     state<=GAP/IDLE as above. A done tick in the same cycle as expiry wins (counts, no timeout).
//   - GAP: counts GAP_CYC clocks, then IDLE. Done ticks in GAP/IDLE are ignored.
//   - Back-to-back throughput: at most one pop per (frame time + GAP_CYC + 1) clocks.
//   - tx_en is sampled only in IDLE. Deassert mid-frame: current frame and gap complete; no new pop.
//   - tx_data holds its value from launch until the next launch.
// CONFIGURATION
//   UART_TX_PARITY_EN defined: tx_parity registered at launch = (^fifo_data) ^ PARITY_ODD,
//     held with tx_data. Undefined: tx_parity constant 0, no parity logic, PARITY_ODD unused.
// TESTING (W=8, GAP_CYC=2, TIMEOUT_CYC=16, CNT_W=16; transmitter model ticks done 10 clks after start)
//   1 Reset: assert reset mid-BUSY -> all outputs 0 immediately; after release, state IDLE, frame_cnt=0.
//   2 Single word: FIFO holds 8'h09, tx_en=1 -> next clk fifo_rd=tx_start=1 for 1 clk, tx_data=8'h09,
//     busy=1; after done tick frame_cnt=1, busy low after 2 gap clks.
//   3 Burst/empty: FIFO holds 8'hA5,8'h3C,8'hFF -> three launches, starts spaced exactly 13 clks apart,
//     frame_cnt=3, no fifo_rd once fifo_empty=1.
//   4 Flow control: drop tx_en during frame 1 of 2 -> frame 1 completes, frame 2 stays in FIFO until
//     tx_en=1; done tick in the tx_start cycle is ignored.
//   5 Watchdog: no done tick -> tx_timeout pulses on BUSY clk 16, frame_cnt unchanged, next word launches
//     after gap; done and expiry same clk -> frame_cnt+1, no timeout. frame_cnt wraps 16'hFFFF->0.
//   6 Parity (UART_TX_PARITY_EN): 8'h07 -> tx_parity=1 (PARITY_ODD=0), 0 (PARITY_ODD=1);
//     macro undefined -> tx_parity=0 always.

Source files
------------

// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl
//   Drain controller that sits between the TX FIFO and the UART transmitter.
//   When the FIFO holds a word and transmit is enabled, it pops the word and
//   launches one frame. It then waits for the transmitter's done tick, with a
//   watchdog as a fallback, and holds an idle gap before the next pop.
//   Optional feature macro: UART_TX_PARITY_EN. When it is defined, a parity
//   bit is registered along with tx_data. When it is undefined, tx_parity is
//   tied to 0.
module uart_tx_fifo_ctrl #(
  parameter int W           = 8,
  parameter int GAP_CYC     = 2,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 16,
  parameter int PARITY_ODD  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [W-1:0]     fifo_data,
  output logic             fifo_rd,
  input  logic             tx_done_tick,
  output logic             tx_start,
  output logic [W-1:0]     tx_data,
  output logic             tx_parity,
  output logic             busy,
  output logic             tx_timeout,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int WW = $clog2(TIMEOUT_CYC);

  // Reject configurations that make the watchdog or parity selection meaningless.
  if (TIMEOUT_CYC < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_tx_fifo_ctrl: TIMEOUT_CYC must be >= 2 and PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // A finished or aborted frame skips the GAP state entirely when no gap is configured.
  localparam state_t S_AFTER = (GAP_CYC == 0) ? S_IDLE : S_GAP;

  state_t           state, state_d;
  logic [GW-1:0]    gap_cnt, gap_cnt_d;
  logic [WW-1:0]    wdog, wdog_d;
  logic [CNT_W-1:0] frame_cnt_d;
  logic             fifo_rd_d, tx_start_d, tx_timeout_d;
  logic             launch;

  // Next-state and next-output decode for the IDLE/BUSY/GAP sequencer.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d      = state;
    gap_cnt_d    = gap_cnt;
    wdog_d       = wdog;
    frame_cnt_d  = frame_cnt;
    fifo_rd_d    = 1'b0;
    tx_start_d   = 1'b0;
    tx_timeout_d = 1'b0;
    launch       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (tx_en && !fifo_empty) begin
          launch     = 1'b1;
          fifo_rd_d  = 1'b1;
          tx_start_d = 1'b1;
          wdog_d     = '0;
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        // tx_start is high only in the first BUSY cycle. A done tick that arrives
        // in that cycle belongs to an older frame and is ignored.
        if (tx_done_tick && !tx_start) begin
          frame_cnt_d = frame_cnt + 1'b1;
          gap_cnt_d   = '0;
          state_d     = S_AFTER;
        end else if (wdog == WW'(TIMEOUT_CYC - 1)) begin
          tx_timeout_d = 1'b1;
          gap_cnt_d    = '0;
          state_d      = S_AFTER;
        end else begin
          wdog_d = wdog + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP_CYC - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered outputs. The launched word is captured only on launch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      gap_cnt    <= '0;
      wdog       <= '0;
      frame_cnt  <= '0;
      fifo_rd    <= 1'b0;
      tx_start   <= 1'b0;
      tx_timeout <= 1'b0;
      busy       <= 1'b0;
      tx_data    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the values from before this edge, whatever order the statements run in.
      state      <= state_d;
      gap_cnt    <= gap_cnt_d;
      wdog       <= wdog_d;
      frame_cnt  <= frame_cnt_d;
      fifo_rd    <= fifo_rd_d;
      tx_start   <= tx_start_d;
      tx_timeout <= tx_timeout_d;
      busy       <= (state_d != S_IDLE);
      if (launch) tx_data <= fifo_data;
    end
  end

`ifdef UART_TX_PARITY_EN
  // The parity bit is captured with the launched word and held alongside tx_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_parity <= 1'b0;
    end else if (launch) begin
      tx_parity <= (^fifo_data) ^ 1'(PARITY_ODD);
    end
  end
`else
  assign tx_parity = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb_uart_tx_fifo_ctrl
//   Directed and randomized bench for uart_tx_fifo_ctrl.
//   The bench models the FIFO as a queue and the transmitter as a done-tick
//   countdown. Expectations are derived from frame arithmetic:
//   start spacing = busy cycles + GAP_CYC + 1, and the timeout pulse follows
//   the TIMEOUT_CYC-th BUSY cycle.
module tb_uart_tx_fifo_ctrl;
  localparam int W           = 8;
  localparam int GAP_CYC     = 2;
  localparam int TIMEOUT_CYC = 16;
  localparam int CNT_W       = 16;
  localparam int PARITY_ODD  = 0;
  localparam int DONE_DLY    = 9;   // done tick in the 10th BUSY cycle: frame time of 10 clocks

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             tx_en, fifo_empty, tx_done_tick;
  logic [W-1:0]     fifo_data, tx_data;
  logic             fifo_rd, tx_start, tx_parity, busy, tx_timeout;
  logic [CNT_W-1:0] frame_cnt;

  uart_tx_fifo_ctrl #(
    .W(W), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W), .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .tx_done_tick(tx_done_tick), .tx_start(tx_start), .tx_data(tx_data),
    .tx_parity(tx_parity), .busy(busy), .tx_timeout(tx_timeout), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [W-1:0] fq[$];        // FIFO contents, head at index 0
  logic [W-1:0] sent[$];      // words expected on the line, in order
  int start_t[$];
  logic [W-1:0] start_d[$];
  logic start_p[$];
  int to_t[$];
  int done_dly, rem, rd_viol, pair_viol, exp_cnt;
  bit inject;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_par(input logic [W-1:0] d);
`ifdef UART_TX_PARITY_EN
    return (^d) ^ 1'(PARITY_ODD);
`else
    return 1'b0;
`endif
  endfunction

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_data  = fifo_empty ? 8'hEE : fq[0];
  endtask

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    sent.push_back(w);
    drive_fifo();
  endtask

  task automatic clear_log();
    start_t.delete(); start_d.delete(); start_p.delete(); to_t.delete(); sent.delete();
  endtask

  // One clock: sample outputs 1 time unit after the edge, then update the FIFO and transmitter models.
  task automatic tick();
    @(posedge clk); #1; cyc++;
    tx_done_tick = 1'b0;
    if (rem > 0) begin
      rem--;
      if (rem == 0) tx_done_tick = 1'b1;
    end
    if (fifo_rd !== tx_start) pair_viol++;
    if (tx_start === 1'b1) begin
      start_t.push_back(cyc); start_d.push_back(tx_data); start_p.push_back(tx_parity);
      if (done_dly > 0) rem = done_dly;
      if (inject) tx_done_tick = 1'b1;
    end
    if (fifo_rd === 1'b1) begin
      if (fq.size() == 0) rd_viol++;
      else void'(fq.pop_front());
    end
    if (tx_timeout === 1'b1) to_t.push_back(cyc);
    drive_fifo();
  endtask

  task automatic tick_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (!((fq.size() == 0 || !tx_en) && busy === 1'b0 && rem == 0) && n < 400) begin
      tick(); n++;
    end
    check({tag, "_drained"}, 32'(n < 400), 1);
  endtask

  task automatic check_burst(input string tag, input int d, input int p);
    check({tag, "_n"}, start_t.size(), sent.size());
    if (start_t.size() > 0) check({tag, "_lat"}, start_t[0] - p, 1);
    foreach (sent[i]) begin
      if (i < start_t.size()) begin
        check($sformatf("%s_data%0d", tag, i), start_d[i], sent[i]);
        check($sformatf("%s_par%0d", tag, i), start_p[i], exp_par(sent[i]));
        if (i > 0) check($sformatf("%s_gap%0d", tag, i), start_t[i] - start_t[i-1], d + 1 + GAP_CYC + 1);
      end
    end
    if (sent.size() > 0) check({tag, "_hold"}, tx_data, sent[sent.size()-1]);
    check({tag, "_cnt"}, frame_cnt, exp_cnt);
  endtask

  initial begin
    int p, n, d;
    logic [W-1:0] w, a, b;
    tx_en = 1'b0; tx_done_tick = 1'b0; done_dly = DONE_DLY; rem = 0; inject = 0;
    rd_viol = 0; pair_viol = 0; exp_cnt = 0;
    drive_fifo();

    // Reset state
    repeat (3) tick();
    check("rst_ctrl", {fifo_rd, tx_start, tx_timeout, busy, tx_parity}, 0);
    check("rst_data", tx_data, 0);
    check("rst_cnt", frame_cnt, 0);
    reset = 1'b0;
    repeat (2) tick();
    check("rst_idle", busy, 0);

    // Single word 8'h09
    clear_log(); tx_en = 1'b1; push(8'h09); p = cyc;
    tick();
    check("t2_rd", fifo_rd, 1);
    check("t2_start", tx_start, 1);
    check("t2_data", tx_data, 8'h09);
    check("t2_busy", busy, 1);
    check("t2_par", tx_parity, exp_par(8'h09));
    tick();
    check("t2_pulse", {fifo_rd, tx_start}, 0);
    tick_until(p + 10);
    check("t2_cnt_before", frame_cnt, 0);
    tick_until(p + 12);
    exp_cnt = 1;
    check("t2_cnt", frame_cnt, exp_cnt);
    check("t2_busy_gap", busy, 1);
    tick();
    check("t2_idle", busy, 0);

    // Parity word 8'h07
    clear_log(); push(8'h07); p = cyc; exp_cnt++;
    wait_drain("t6");
    check_burst("t6", DONE_DLY, p);

    // Fixed burst, 13-clock spacing
    clear_log(); push(8'hA5); push(8'h3C); push(8'hFF); p = cyc; exp_cnt += 3;
    wait_drain("t3");
    check_burst("t3", DONE_DLY, p);

    // Randomized bursts with random frame times
    for (int r = 0; r < 3; r++) begin
      clear_log();
      n = $urandom_range(2, 5);
      d = $urandom_range(1, TIMEOUT_CYC - 2);
      done_dly = d;
      for (int k = 0; k < n; k++) begin
        w = W'($urandom);
        push(w);
      end
      p = cyc; exp_cnt += n;
      wait_drain($sformatf("rnd%0d", r));
      check_burst($sformatf("rnd%0d", r), d, p);
    end

    // Flow control and a done tick in the tx_start cycle
    clear_log(); done_dly = DONE_DLY; inject = 1;
    a = W'($urandom); b = W'($urandom);
    push(a); push(b); p = cyc;
    tick();
    inject = 0; tx_en = 1'b0;
    check("t4_start", tx_start, 1);
    tick_until(p + 5);
    check("t4_ign_busy", busy, 1);
    check("t4_ign_cnt", frame_cnt, exp_cnt);
    tick_until(p + 40);
    exp_cnt++;
    check("t4_hold_n", start_t.size(), 1);
    check("t4_fifo_left", fq.size(), 1);
    check("t4_cnt1", frame_cnt, exp_cnt);
    check("t4_idle", busy, 0);
    tx_en = 1'b1;
    wait_drain("t4");
    exp_cnt++;
    check("t4_n", start_t.size(), 2);
    if (start_d.size() > 1) check("t4_data2", start_d[1], b);
    check("t4_cnt2", frame_cnt, exp_cnt);

    // Watchdog: no done for the first frame, then a normal frame
    clear_log(); done_dly = 0;
    push(W'($urandom)); push(W'($urandom)); p = cyc;
    tick();
    done_dly = DONE_DLY;
    wait_drain("t5");
    exp_cnt++;
    check("t5_to_n", to_t.size(), 1);
    if (to_t.size() > 0) check("t5_to_t", to_t[0], p + 1 + TIMEOUT_CYC);
    check("t5_n", start_t.size(), 2);
    if (start_t.size() > 1) check("t5_gap", start_t[1] - start_t[0], TIMEOUT_CYC + GAP_CYC + 1);
    check("t5_cnt", frame_cnt, exp_cnt);

    // Done in the expiry cycle wins
    clear_log(); done_dly = TIMEOUT_CYC - 1; push(W'($urandom));
    wait_drain("t5b");
    exp_cnt++;
    check("t5b_to_n", to_t.size(), 0);
    check("t5b_cnt", frame_cnt, exp_cnt);

    // Done one cycle after expiry is too late
    clear_log(); done_dly = TIMEOUT_CYC; push(W'($urandom));
    wait_drain("t5c");
    check("t5c_to_n", to_t.size(), 1);
    check("t5c_cnt", frame_cnt, exp_cnt);

    // Reset in the middle of a frame
    clear_log(); done_dly = DONE_DLY;
    push(W'($urandom)); push(W'($urandom)); p = cyc;
    tick_until(p + 4);
    check("t1_busy", busy, 1);
    reset = 1'b1; tx_en = 1'b0; #1;
    check("t1_ctrl", {fifo_rd, tx_start, tx_timeout, busy, tx_parity}, 0);
    check("t1_data", tx_data, 0);
    check("t1_cnt", frame_cnt, 0);
    rem = 0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    check("t1_idle", busy, 0);
    check("t1_cnt_rel", frame_cnt, 0);
    check("t1_fifo_kept", fq.size(), 1);
    tx_en = 1'b1;
    wait_drain("t1");
    check("t1_cnt_after", frame_cnt, 1);

    check("rd_when_empty", rd_viol, 0);
    check("rd_start_pair", pair_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
